lc3b_control: RTL and testbench
===============================

# lc3b_control

Multicycle control FSM for the LC-3b mp1 datapath. Sequences every instruction through fetch, decode and execute. Drives the load enables for PC, MAR, MDR, IR, regfile and CC, plus all datapath mux selects, the ALU op and the memory handshake. Consumes the decoded opcode and flag fields from the instruction register and the branch-enable comparison from the datapath.

## Interface
Parameters:
- none (all widths come from `lc3b_types`)

Ports:
- `clk` in 1: datapath clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `opcode` in `lc3b_opcode`: IR[15:12].
- `imm5_enable` in 1: IR[5]; selects immediate for ADD/AND.
- `branch_enable` in 1: NZP match of IR[11:9] against CC.
- `mem_resp` in 1: memory handshake complete.
- `load_pc`, `load_ir`, `load_regfile`, `load_mar`, `load_mdr`, `load_cc` out 1 each: register load enables.
- `pcmux_sel` out 1: 0 = PC+2, 1 = PC + (offset9<<1).
- `storemux_sel` out 1: SR1 address; 0 = IR[8:6], 1 = IR[11:9] (STR).
- `alumux_sel` out 2: 0 = SR2 reg, 1 = sext(imm5), 2 = sext(offset6)<<1.
- `regfilemux_sel` out 1: 0 = alu_out, 1 = MDR.
- `marmux_sel` out 1: 0 = alu_out, 1 = PC.
- `mdrmux_sel` out 1: 0 = alu_out, 1 = mem_rdata.
- `aluop` out `lc3b_aluop`: alu_add / alu_and / alu_not / alu_pass.
- `mem_read`, `mem_write` out 1: memory strobes.
- `mem_byte_enable` out 2: fixed 2'b11.
- `instr_count` out 32: present only with `LC3B_CTRL_ICOUNT_EN`.

## Operation
- States:
  - Fetch: FETCH1, FETCH2, FETCH3.
  - DECODE.
  - ALU: S_ADD, S_AND, S_NOT.
  - Branch: S_BR, S_BR_TAKEN.
  - Memory: S_CALC_ADDR, S_LDR1, S_LDR2, S_STR1, S_STR2.
- FETCH1: `marmux_sel`=1, `load_mar`, `load_pc` with `pcmux_sel`=0. Go to FETCH2.
- FETCH2: `mem_read`, `mdrmux_sel`=1, `load_mdr`. Hold in FETCH2 until `mem_resp`=1, then go to FETCH3.
- FETCH3: `load_ir`. Go to DECODE.
- DECODE: no loads. Branch on `opcode`:
  - op_add → S_ADD
  - op_and → S_AND
  - op_not → S_NOT
  - op_br → S_BR
  - op_ldr, op_str → S_CALC_ADDR
  - any other opcode → FETCH1 (executes as NOP)
- S_ADD / S_AND:
  - `aluop` = add / and.
  - `alumux_sel` = `imm5_enable` ? 1 : 0.
  - `regfilemux_sel`=0, `load_regfile`, `load_cc`.
  - Go to FETCH1.
- S_NOT: `aluop`=alu_not, `load_regfile`, `load_cc`. Go to FETCH1.
- S_BR: if `branch_enable` go to S_BR_TAKEN, else go to FETCH1.
- S_BR_TAKEN: `pcmux_sel`=1, `load_pc`. Go to FETCH1.
- S_CALC_ADDR: `alumux_sel`=2, `aluop`=alu_add, `marmux_sel`=0, `load_mar`. Go to S_LDR1 for LDR, S_STR1 for STR.
- S_LDR1: `mem_read`, `mdrmux_sel`=1, `load_mdr`. Hold until `mem_resp`, then go to S_LDR2.
- S_LDR2: `regfilemux_sel`=1, `load_regfile`, `load_cc`. Go to FETCH1.
- S_STR1: `storemux_sel`=1, `aluop`=alu_pass, `mdrmux_sel`=0, `load_mdr`. Go to S_STR2.
- S_STR2: `mem_write`. Hold until `mem_resp`, then go to FETCH1.
- Defaults: every output not listed for the current state is 0. `aluop` defaults to alu_add. `mem_byte_enable` is always 2'b11.
- Outputs are a pure combinational function of state (plus `imm5_enable` in S_ADD/S_AND). No output depends on `mem_resp`.

## Timing
- Reset:
  - State goes to FETCH1 at the first rising edge with `reset`=1.
  - All strobes and loads are 0 while in reset, except the FETCH1 decode, which is present from the cycle after reset is released.
- Reset asserted during FETCH2, S_LDR1 or S_STR2:
  - The strobe drops the cycle after the reset edge.
  - A `mem_resp` arriving in that cycle is ignored.
- Memory strobes stay high for every cycle spent in a wait state, including the `mem_resp` cycle. They drop on the following edge.
- Cycle counts, assuming `mem_resp` returns in the first strobe cycle:
  - ADD/AND/NOT: 5 cycles.
  - BR not taken: 5 cycles.
  - BR taken: 6 cycles.
  - LDR: 7 cycles.
  - STR: 7 cycles.
  - Unknown opcode: 4 cycles.
- Each cycle of memory wait adds exactly 1 cycle.
- `mem_read` and `mem_write` are never high together.

## Configuration
- `LC3B_CTRL_ICOUNT_EN` defined:
  - 32-bit `instr_count` port present.
  - Reset value 0.
  - Increments by 1 on each clock edge taken while in DECODE, so it counts every instruction including NOPs.
  - Wraps from 0xFFFFFFFF to 0.
- `LC3B_CTRL_ICOUNT_EN` undefined: port and counter are absent. FSM behaviour is identical.

## Test plan
- Reset then ADD R1,R2,#3 (IR=0x12A3), `mem_resp` held 1 → `load_ir` in cycle 3, and in cycle 5 `alumux_sel`=1, `load_regfile`=1, `load_cc`=1. FETCH1 resumes in cycle 6.
- AND register form (IR=0x5242) → `alumux_sel`=0, `aluop`=alu_and in the execute state.
- BR with `branch_enable`=1 → S_BR_TAKEN asserts `pcmux_sel`=1 and `load_pc`. With `branch_enable`=0, no PC load after fetch and the instruction takes 5 cycles.
- LDR with `mem_resp` delayed 3 cycles in both FETCH2 and S_LDR1 → `mem_read` is high for 4 cycles in each, and the instruction takes 13 cycles total.
- STR → S_STR1 shows `storemux_sel`=1, `mdrmux_sel`=0, `load_mdr`. `mem_write` is high until `mem_resp`. `mem_read`/`mem_write` are never simultaneously high.
- Reset pulsed in S_STR2 with ICOUNT_EN → `mem_write` drops next cycle, state is FETCH1, `instr_count`=0. After 3 unknown-opcode instructions, `instr_count`=3.

Source files
------------

// File: rtl/lc3b_control.sv
// Multicycle control FSM for the LC-3b mp1 datapath (fetch / decode / execute).
// Optional instruction counter port enabled by defining LC3B_CTRL_ICOUNT_EN.

package lc3b_types;

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  typedef enum logic [3:0] {
    alu_add,
    alu_and,
    alu_not,
    alu_pass,
    alu_sll,
    alu_srl,
    alu_sra
  } lc3b_aluop;

endpackage

module lc3b_control
  import lc3b_types::*;
(
  input  logic        clk,
  input  logic        reset,
  input  lc3b_opcode  opcode,
  input  logic        imm5_enable,
  input  logic        branch_enable,
  input  logic        mem_resp,
  output logic        load_pc,
  output logic        load_ir,
  output logic        load_regfile,
  output logic        load_mar,
  output logic        load_mdr,
  output logic        load_cc,
  output logic        pcmux_sel,
  output logic        storemux_sel,
  output logic [1:0]  alumux_sel,
  output logic        regfilemux_sel,
  output logic        marmux_sel,
  output logic        mdrmux_sel,
  output lc3b_aluop   aluop,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_byte_enable
`ifdef LC3B_CTRL_ICOUNT_EN
  ,
  output logic [31:0] instr_count
`endif
);

  typedef enum logic [3:0] {
    FETCH1,
    FETCH2,
    FETCH3,
    DECODE,
    S_ADD,
    S_AND,
    S_NOT,
    S_BR,
    S_BR_TAKEN,
    S_CALC_ADDR,
    S_LDR1,
    S_LDR2,
    S_STR1,
    S_STR2
  } state_e;

  state_e state_q, state_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH1;
    else       state_q <= state_d;
  end

  assign mem_byte_enable = 2'b11;

  // NOTE: every signal driven here gets a default before the case, so no path
  // leaves one unassigned and no latch can be inferred.
  always_comb begin
    state_d        = state_q;
    load_pc        = 1'b0;
    load_ir        = 1'b0;
    load_regfile   = 1'b0;
    load_mar       = 1'b0;
    load_mdr       = 1'b0;
    load_cc        = 1'b0;
    pcmux_sel      = 1'b0;
    storemux_sel   = 1'b0;
    alumux_sel     = 2'd0;
    regfilemux_sel = 1'b0;
    marmux_sel     = 1'b0;
    mdrmux_sel     = 1'b0;
    aluop          = alu_add;
    mem_read       = 1'b0;
    mem_write      = 1'b0;

    // While reset is held all strobes stay idle; the register forces FETCH1.
    if (!reset) begin
      unique case (state_q)
        FETCH1: begin
          marmux_sel = 1'b1;
          load_mar   = 1'b1;
          load_pc    = 1'b1;
          state_d    = FETCH2;
        end
        FETCH2: begin
          mem_read   = 1'b1;
          mdrmux_sel = 1'b1;
          load_mdr   = 1'b1;
          if (mem_resp) state_d = FETCH3;
        end
        FETCH3: begin
          load_ir = 1'b1;
          state_d = DECODE;
        end
        DECODE: begin
          case (opcode)
            op_add:         state_d = S_ADD;
            op_and:         state_d = S_AND;
            op_not:         state_d = S_NOT;
            op_br:          state_d = S_BR;
            op_ldr, op_str: state_d = S_CALC_ADDR;
            default:        state_d = FETCH1;
          endcase
        end
        S_ADD, S_AND: begin
          aluop        = (state_q == S_AND) ? alu_and : alu_add;
          alumux_sel   = imm5_enable ? 2'd1 : 2'd0;
          load_regfile = 1'b1;
          load_cc      = 1'b1;
          state_d      = FETCH1;
        end
        S_NOT: begin
          aluop        = alu_not;
          load_regfile = 1'b1;
          load_cc      = 1'b1;
          state_d      = FETCH1;
        end
        S_BR: begin
          state_d = branch_enable ? S_BR_TAKEN : FETCH1;
        end
        S_BR_TAKEN: begin
          pcmux_sel = 1'b1;
          load_pc   = 1'b1;
          state_d   = FETCH1;
        end
        S_CALC_ADDR: begin
          alumux_sel = 2'd2;
          load_mar   = 1'b1;
          state_d    = (opcode == op_ldr) ? S_LDR1 : S_STR1;
        end
        S_LDR1: begin
          mem_read   = 1'b1;
          mdrmux_sel = 1'b1;
          load_mdr   = 1'b1;
          if (mem_resp) state_d = S_LDR2;
        end
        S_LDR2: begin
          regfilemux_sel = 1'b1;
          load_regfile   = 1'b1;
          load_cc        = 1'b1;
          state_d        = FETCH1;
        end
        S_STR1: begin
          storemux_sel = 1'b1;
          aluop        = alu_pass;
          load_mdr     = 1'b1;
          state_d      = S_STR2;
        end
        S_STR2: begin
          mem_write = 1'b1;
          if (mem_resp) state_d = FETCH1;
        end
        default: state_d = FETCH1;
      endcase
    end
  end

`ifdef LC3B_CTRL_ICOUNT_EN
  logic [31:0] count_q;

  // One increment per pass through DECODE, so NOPs are counted too.
  always_ff @(posedge clk) begin
    if (reset)                 count_q <= 32'd0;
    else if (state_q == DECODE) count_q <= count_q + 32'd1;
  end

  assign instr_count = count_q;
`endif

endmodule

// File: tb/tb_lc3b_control.sv
// Self-checking bench for lc3b_control: per-cycle output vectors plus
// multi-cycle sequences for memory waits, cycle counts and mid-access reset.

module tb_lc3b_control;
  import lc3b_types::*;

  logic        clk;
  logic        reset;
  lc3b_opcode  opcode;
  logic        imm5_enable;
  logic        branch_enable;
  logic        mem_resp;
  logic        load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc;
  logic        pcmux_sel, storemux_sel, regfilemux_sel, marmux_sel, mdrmux_sel;
  logic [1:0]  alumux_sel;
  lc3b_aluop   aluop;
  logic        mem_read, mem_write;
  logic [1:0]  mem_byte_enable;
`ifdef LC3B_CTRL_ICOUNT_EN
  logic [31:0] instr_count;
`endif

  lc3b_control dut (
    .clk            (clk),
    .reset          (reset),
    .opcode         (opcode),
    .imm5_enable    (imm5_enable),
    .branch_enable  (branch_enable),
    .mem_resp       (mem_resp),
    .load_pc        (load_pc),
    .load_ir        (load_ir),
    .load_regfile   (load_regfile),
    .load_mar       (load_mar),
    .load_mdr       (load_mdr),
    .load_cc        (load_cc),
    .pcmux_sel      (pcmux_sel),
    .storemux_sel   (storemux_sel),
    .alumux_sel     (alumux_sel),
    .regfilemux_sel (regfilemux_sel),
    .marmux_sel     (marmux_sel),
    .mdrmux_sel     (mdrmux_sel),
    .aluop          (aluop),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_byte_enable(mem_byte_enable)
`ifdef LC3B_CTRL_ICOUNT_EN
    ,
    .instr_count    (instr_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       ld_pc, ld_ir, ld_rf, ld_mar, ld_mdr, ld_cc, pcmux, storemux;
    logic [1:0] alumux;
    logic       rfmux, marmux, mdrmux;
    lc3b_aluop  aluop;
    logic       mrd, mwr;
    logic [1:0] be;
  } outs_t;

  typedef struct {
    logic       rst;
    lc3b_opcode op;
    logic       imm5;
    logic       br_en;
    logic       resp;
    outs_t      exp;
    string      name;
  } vec_t;

  outs_t act;
  assign act = {load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc,
                pcmux_sel, storemux_sel, alumux_sel, regfilemux_sel, marmux_sel,
                mdrmux_sel, aluop, mem_read, mem_write, mem_byte_enable};

  outs_t o_idle, o_f1, o_f2, o_f3, o_addi, o_addr, o_andi, o_andr, o_not, o_brt;
  outs_t o_calc, o_ldr1, o_ldr2, o_str1, o_str2;

  vec_t vecs[$];
  int   runs[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   overlap  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
  endtask

  function automatic outs_t base();
    outs_t o;
    o       = '0;
    o.aluop = alu_add;
    o.be    = 2'b11;
    return o;
  endfunction

  task automatic add(input logic r, input lc3b_opcode op, input logic im, input logic be,
                     input logic rs, input outs_t e, input string n);
    vec_t v;
    v.rst = r; v.op = op; v.imm5 = im; v.br_en = be; v.resp = rs; v.exp = e; v.name = n;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    mem_resp = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  function automatic logic is_f1();
    return load_pc && load_mar && marmux_sel && !pcmux_sel;
  endfunction

  // Runs from the current cycle until FETCH1 is seen again; the responder
  // answers each wait state after 'delay' extra strobe cycles.
  task automatic run_instr(input lc3b_opcode op, input logic br, input int delay, output int len);
    int streak;
    opcode        = op;
    branch_enable = br;
    imm5_enable   = 1'b0;
    len           = -1;
    streak        = 0;
    runs.delete();
    for (int c = 0; c < 60; c++) begin
      if (c > 0 && is_f1()) begin
        len = c;
        break;
      end
      if (mem_read || mem_write) begin
        mem_resp = (streak == delay);
        streak++;
      end else begin
        if (streak > 0) runs.push_back(streak);
        streak   = 0;
        mem_resp = 1'b0;
      end
      @(negedge clk);
      if (mem_read && mem_write) overlap++;
      @(posedge clk); #1;
    end
    if (streak > 0) runs.push_back(streak);
    mem_resp = 1'b0;
  endtask

  initial begin
    int len;
    int found;

    o_idle = base();
    o_f1   = base(); o_f1.ld_pc = 1; o_f1.ld_mar = 1; o_f1.marmux = 1;
    o_f2   = base(); o_f2.mrd = 1; o_f2.mdrmux = 1; o_f2.ld_mdr = 1;
    o_f3   = base(); o_f3.ld_ir = 1;
    o_addi = base(); o_addi.alumux = 2'd1; o_addi.ld_rf = 1; o_addi.ld_cc = 1;
    o_addr = base(); o_addr.ld_rf = 1; o_addr.ld_cc = 1;
    o_andi = o_addi; o_andi.aluop = alu_and;
    o_andr = o_addr; o_andr.aluop = alu_and;
    o_not  = base(); o_not.aluop = alu_not; o_not.ld_rf = 1; o_not.ld_cc = 1;
    o_brt  = base(); o_brt.pcmux = 1; o_brt.ld_pc = 1;
    o_calc = base(); o_calc.alumux = 2'd2; o_calc.ld_mar = 1;
    o_ldr1 = o_f2;
    o_ldr2 = base(); o_ldr2.rfmux = 1; o_ldr2.ld_rf = 1; o_ldr2.ld_cc = 1;
    o_str1 = base(); o_str1.storemux = 1; o_str1.aluop = alu_pass; o_str1.ld_mdr = 1;
    o_str2 = base(); o_str2.mwr = 1;

    // ADD R1,R2,#3 (0x12A3): imm5 set
    add(1, op_add, 1, 0, 1, o_idle, "rst_hold");
    add(0, op_add, 1, 0, 1, o_f1,   "add_f1");
    add(0, op_add, 1, 0, 1, o_f2,   "add_f2");
    add(0, op_add, 1, 0, 1, o_f3,   "add_f3_load_ir");
    add(0, op_add, 1, 0, 1, o_idle, "add_decode");
    add(0, op_add, 1, 0, 1, o_addi, "add_exec");
    // AND register form (0x5242), one fetch wait cycle
    add(0, op_and, 0, 0, 0, o_f1,   "and_f1");
    add(0, op_and, 0, 0, 0, o_f2,   "and_f2_wait");
    add(0, op_and, 0, 0, 1, o_f2,   "and_f2_resp");
    add(0, op_and, 0, 0, 1, o_f3,   "and_f3");
    add(0, op_and, 0, 0, 1, o_idle, "and_decode");
    add(0, op_and, 0, 0, 1, o_andr, "and_exec");
    add(0, op_and, 1, 0, 1, o_f1,   "andi_f1");
    add(0, op_and, 1, 0, 1, o_f2,   "andi_f2");
    add(0, op_and, 1, 0, 1, o_f3,   "andi_f3");
    add(0, op_and, 1, 0, 1, o_idle, "andi_decode");
    add(0, op_and, 1, 0, 1, o_andi, "andi_exec");
    add(0, op_not, 0, 0, 1, o_f1,   "not_f1");
    add(0, op_not, 0, 0, 1, o_f2,   "not_f2");
    add(0, op_not, 0, 0, 1, o_f3,   "not_f3");
    add(0, op_not, 0, 0, 1, o_idle, "not_decode");
    add(0, op_not, 0, 0, 1, o_not,  "not_exec");
    add(0, op_br,  0, 1, 1, o_f1,   "brt_f1");
    add(0, op_br,  0, 1, 1, o_f2,   "brt_f2");
    add(0, op_br,  0, 1, 1, o_f3,   "brt_f3");
    add(0, op_br,  0, 1, 1, o_idle, "brt_decode");
    add(0, op_br,  0, 1, 1, o_idle, "brt_s_br");
    add(0, op_br,  0, 1, 1, o_brt,  "brt_taken");
    add(0, op_br,  0, 0, 1, o_f1,   "brn_f1");
    add(0, op_br,  0, 0, 1, o_f2,   "brn_f2");
    add(0, op_br,  0, 0, 1, o_f3,   "brn_f3");
    add(0, op_br,  0, 0, 1, o_idle, "brn_decode");
    add(0, op_br,  0, 0, 1, o_idle, "brn_s_br");
    add(0, op_shf, 0, 0, 1, o_f1,   "nop_f1");
    add(0, op_shf, 0, 0, 1, o_f2,   "nop_f2");
    add(0, op_shf, 0, 0, 1, o_f3,   "nop_f3");
    add(0, op_shf, 0, 0, 1, o_idle, "nop_decode");
    add(0, op_add, 0, 0, 1, o_f1,   "addr_f1");
    add(0, op_add, 0, 0, 1, o_f2,   "addr_f2");
    add(0, op_add, 0, 0, 1, o_f3,   "addr_f3");
    add(0, op_add, 0, 0, 1, o_idle, "addr_decode");
    add(0, op_add, 0, 0, 1, o_addr, "addr_exec");
    add(0, op_ldr, 0, 0, 1, o_f1,   "ldr_f1");
    add(0, op_ldr, 0, 0, 1, o_f2,   "ldr_f2");
    add(0, op_ldr, 0, 0, 1, o_f3,   "ldr_f3");
    add(0, op_ldr, 0, 0, 1, o_idle, "ldr_decode");
    add(0, op_ldr, 0, 0, 1, o_calc, "ldr_calc");
    add(0, op_ldr, 0, 0, 1, o_ldr1, "ldr_1");
    add(0, op_ldr, 0, 0, 1, o_ldr2, "ldr_2");
    add(0, op_str, 0, 0, 1, o_f1,   "str_f1");
    add(0, op_str, 0, 0, 1, o_f2,   "str_f2");
    add(0, op_str, 0, 0, 1, o_f3,   "str_f3");
    add(0, op_str, 0, 0, 1, o_idle, "str_decode");
    add(0, op_str, 0, 0, 1, o_calc, "str_calc");
    add(0, op_str, 0, 0, 1, o_str1, "str_1");
    add(0, op_str, 0, 0, 0, o_str2, "str_2_wait");
    add(0, op_str, 0, 0, 1, o_str2, "str_2_resp");
    add(1, op_add, 0, 0, 1, o_idle, "rst_gate_f1");
    add(0, op_add, 0, 0, 1, o_f1,   "post_rst_f1");

    reset         = 1'b1;
    opcode        = op_add;
    imm5_enable   = 1'b0;
    branch_enable = 1'b0;
    mem_resp      = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      reset         = vecs[i].rst;
      opcode        = vecs[i].op;
      imm5_enable   = vecs[i].imm5;
      branch_enable = vecs[i].br_en;
      mem_resp      = vecs[i].resp;
      @(negedge clk);
      if (mem_read && mem_write) overlap++;
      check(vecs[i].name, 32'(act), 32'(vecs[i].exp));
      @(posedge clk); #1;
    end

    // LDR with three extra wait cycles in both fetch and load
    do_reset();
    run_instr(op_ldr, 1'b0, 3, len);
    check("ldr_wait_len", 32'(len), 32'd13);
    check("ldr_wait_runs", 32'(runs.size()), 32'd2);
    if (runs.size() == 2) begin
      check("ldr_fetch_rd_cycles", 32'(runs[0]), 32'd4);
      check("ldr_load_rd_cycles",  32'(runs[1]), 32'd4);
    end

    run_instr(op_str, 1'b0, 2, len);
    check("str_wait_len", 32'(len), 32'd11);
    if (runs.size() == 2) check("str_wr_cycles", 32'(runs[1]), 32'd3);
    else check("str_wait_runs", 32'(runs.size()), 32'd2);

    run_instr(op_br,  1'b1, 0, len); check("len_br_taken",  32'(len), 32'd6);
    run_instr(op_br,  1'b0, 0, len); check("len_br_not",    32'(len), 32'd5);
    run_instr(op_not, 1'b0, 0, len); check("len_not",       32'(len), 32'd5);
    run_instr(op_str, 1'b0, 0, len); check("len_str",       32'(len), 32'd7);
    run_instr(op_ldr, 1'b0, 0, len); check("len_ldr",       32'(len), 32'd7);
    run_instr(op_trap, 1'b0, 0, len); check("len_unknown",  32'(len), 32'd4);

    // Reset while S_STR2 is waiting on memory
    do_reset();
    opcode = op_str;
    found  = 0;
    for (int c = 0; c < 20; c++) begin
      if (mem_write) begin
        found = 1;
        break;
      end
      mem_resp = 1'b1;
      @(posedge clk); #1;
    end
    check("str2_reached", 32'(found), 32'd1);
    mem_resp = 1'b0;
    reset    = 1'b1;
    @(posedge clk); #1;
    reset    = 1'b0;
    mem_resp = 1'b1;
    @(negedge clk);
    check("rst_str2_wr_drop", 32'(mem_write), 32'd0);
    check("rst_str2_fetch1",  32'(act), 32'(o_f1));
`ifdef LC3B_CTRL_ICOUNT_EN
    check("icount_after_rst", instr_count, 32'd0);
`endif
    @(posedge clk); #1;
    check("rst_resp_ignored_f2", 32'(act), 32'(o_f2));

    run_instr(op_shf, 1'b0, 0, len);
    check("nop1_tail_len", 32'(len), 32'd3);
    run_instr(op_jmp, 1'b0, 0, len); check("nop2_len", 32'(len), 32'd4);
    run_instr(op_lea, 1'b0, 0, len); check("nop3_len", 32'(len), 32'd4);
`ifdef LC3B_CTRL_ICOUNT_EN
    check("icount_three_nops", instr_count, 32'd3);
`endif

    check("rd_wr_never_both", 32'(overlap), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
